// File: rtl/scr1_ahb_sram_slv.sv
// -----------------------------------------------------------------------------
// scr1_ahb_sram_slv
//   AHB-Lite responder backed by a single-port 32-bit word SRAM. Answers
//   NONSEQ/SEQ beats with WAIT_STATES low-HREADYOUT cycles per data phase and
//   supports back-to-back pipelined beats. IDLE/BUSY or unselected cycles
//   produce no data phase.
//
//   Optional feature macro: SCR1_AHB_SLV_ERRRESP_EN
//     defined   : out-of-range, hsize>2 and misaligned beats get a two-cycle
//                 ERROR response with no write and zero read data.
//     undefined : hresp tied 0, offset wraps modulo the memory size,
//                 misaligned addresses are aligned down, hsize>2 acts as word.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   hsel, haddr, htrans   address-phase select / address / transfer type
//   hwrite, hsize         direction, transfer size (0 byte, 1 half, 2 word)
//   hburst, hprot,
//   hmastlock             accepted but ignored
//   hwdata                write data, valid in the data phase
//   hready                bus ready, qualifies the address phase
//   hreadyout             data-phase completion
//   hrdata                read data (full word), zero outside read completion
//   hresp                 0 OKAY, 1 ERROR
// -----------------------------------------------------------------------------
module scr1_ahb_sram_slv #(
   parameter int unsigned MEM_WORDS   = 1024,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [3:0]  hprot,
   input  logic        hmastlock,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic        hreadyout,
   output logic [31:0] hrdata,
   output logic        hresp
);

   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam logic [3:0]  WS = 4'(WAIT_STATES);

`ifdef SCR1_AHB_SLV_ERRRESP_EN
   localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
   typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} state_e;
`else
   typedef enum logic [1:0] {StIdle, StData} state_e;
`endif

   state_e         state_q;
   logic [3:0]     wait_cnt;
   logic [AW-1:0]  idx_q;
   logic [3:0]     be_q;
   logic           write_q;
   logic [31:0]    mem [MEM_WORDS];

   logic           accept;
   logic           done;
   logic           take;
   logic           dec_err;
   logic [31:0]    offset;
   logic [3:0]     be;
   logic           we;

   assign accept = hsel & htrans[1] & hready;
   assign offset = haddr - BASE_ADDR;
   assign done   = (state_q == StData) & hreadyout;

   // A new beat is only sampled when no data phase is stalling the bus.
`ifdef SCR1_AHB_SLV_ERRRESP_EN
   logic resp_q;
   assign take    = accept & ((state_q == StIdle) | done | (state_q == StErr2));
   assign dec_err = (offset >= MEM_BYTES) | (hsize > 3'd2)
                  | ((hsize == 3'd1) & offset[0])
                  | ((hsize == 3'd2) & (offset[1:0] != 2'b00));
   assign hresp   = resp_q;
`else
   assign take    = accept & ((state_q == StIdle) | done);
   assign dec_err = 1'b0;
   assign hresp   = 1'b0;
`endif

   // Lane enables; misaligned halves/words fall back to their aligned lanes.
   always_comb begin
      be = 4'b1111;
      case (hsize)
         3'd0:    be = 4'b0001 << offset[1:0];
         3'd1:    be = offset[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         wait_cnt  <= 4'd0;
         hreadyout <= 1'b1;
         idx_q     <= '0;
         be_q      <= 4'b0000;
         write_q   <= 1'b0;
`ifdef SCR1_AHB_SLV_ERRRESP_EN
         resp_q    <= 1'b0;
`endif
      end else if (take) begin
         idx_q    <= offset[AW+1:2];
         be_q     <= be;
         write_q  <= hwrite;
         wait_cnt <= 4'd0;
         if (dec_err) begin
`ifdef SCR1_AHB_SLV_ERRRESP_EN
            state_q   <= StErr1;
            hreadyout <= 1'b0;
            resp_q    <= 1'b1;
`endif
         end else begin
            state_q   <= StData;
            hreadyout <= (WS == 4'd0);
`ifdef SCR1_AHB_SLV_ERRRESP_EN
            resp_q    <= 1'b0;
`endif
         end
      end else begin
         unique case (state_q)
            StData: begin
               if (!hreadyout) begin
                  wait_cnt  <= wait_cnt + 4'd1;
                  hreadyout <= ((wait_cnt + 4'd1) == WS);
               end else begin
                  state_q <= StIdle;
               end
            end
`ifdef SCR1_AHB_SLV_ERRRESP_EN
            StErr1: begin
               state_q   <= StErr2;
               hreadyout <= 1'b1;
            end
            StErr2: begin
               state_q <= StIdle;
               resp_q  <= 1'b0;
            end
`endif
            default: ;
         endcase
      end
   end

   // Commit on the completion edge; a reset at that edge drops the write.
   assign we = done & write_q & ~rst;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
         end
      end
   end

   assign hrdata = (done & ~write_q) ? mem[idx_q] : 32'h0;

   logic unused;
   assign unused = ^{hburst, hprot, hmastlock, offset[31:AW+2]};

endmodule
